// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Access lengths are kept in bytes (1/2/4) so the counters compare directly.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;

  // addr[17:16] value that selects the IO space (UART output)
  localparam logic [1:0] IO_SEL = 2'b11;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_LSB = 1'b1;

  function automatic logic [2:0] byte_len(input logic [1:0] width);
    case (width)
      WIDTH_B: return 3'd1;
      WIDTH_H: return 3'd2;
      WIDTH_W: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-side request/response bundle: instruction fetch and load/store buffer.
// The core front ends drive the master side, mem_ctrl implements the slave side.
interface mem_ctrl_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;

  logic        lsb_req;
  logic        lsb_we;
  logic [1:0]  lsb_width;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

  modport master (
    output if_req, if_addr,
    input  if_done, if_data,
    output lsb_req, lsb_we, lsb_width, lsb_addr, lsb_wdata,
    input  lsb_done, lsb_rdata
  );

  modport slave (
    input  if_req, if_addr,
    output if_done, if_data,
    input  lsb_req, lsb_we, lsb_width, lsb_addr, lsb_wdata,
    output lsb_done, lsb_rdata
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and LSB accesses onto a byte-wide RAM port, serialising
// each access into byte transfers and assembling little-endian read data.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        io_buffer_full,
  mem_ctrl_if.slave   bus,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        if_done_q, if_done_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;

  logic [2:0]  cnt_inc;
  logic [1:0]  rd_idx;
  logic        lsb_ok, if_ok;
  logic        io_hold, accept_io_hold;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    asm_d       = asm_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    if_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    if_data_d   = if_data_q;
    lsb_rdata_d = lsb_rdata_q;

    cnt_inc = cnt_q + 3'd1;
    // In READ, cnt_q counts cycles since the first address; byte cnt_q-1 is on mem_din
    rd_idx  = cnt_q[1:0] - 2'd1;
    // A requester still holds req during its own done cycle, so that req is ignored
    lsb_ok  = bus.lsb_req && !lsb_done_q;
    if_ok   = bus.if_req && !if_done_q;
    io_hold        = (addr_q[17:16] == IO_SEL) && io_buffer_full;
    accept_io_hold = (bus.lsb_addr[17:16] == IO_SEL) && io_buffer_full;

    case (state_q)
      IDLE: begin
        if (!rob_clear) begin
          if (lsb_ok) begin
            owner_d = OWNER_LSB;
            addr_d  = bus.lsb_addr;
            len_d   = byte_len(bus.lsb_width);
            cnt_d   = 3'd0;
            mem_a_d = bus.lsb_addr;
            if (bus.lsb_we) begin
              state_d    = WRITE;
              mem_dout_d = bus.lsb_wdata[7:0];
              asm_d      = bus.lsb_wdata >> 8;
              mem_wr_d   = !accept_io_hold;
            end else begin
              state_d  = READ;
              asm_d    = '0;
              mem_wr_d = 1'b0;
            end
          end else if (if_ok) begin
            owner_d  = OWNER_IF;
            addr_d   = bus.if_addr;
            len_d    = 3'd4;
            cnt_d    = 3'd0;
            mem_a_d  = bus.if_addr;
            asm_d    = '0;
            mem_wr_d = 1'b0;
            state_d  = READ;
          end
        end
      end

      READ: begin
        if (rob_clear) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc < len_q) begin
            mem_a_d = addr_q + {29'd0, cnt_inc};
          end
          if (cnt_q != 3'd0) begin
            asm_d = asm_q | ({24'd0, mem_din} << {rd_idx, 3'b000});
            if (cnt_q == len_q) begin
              state_d = IDLE;
              cnt_d   = 3'd0;
              if (owner_q == OWNER_LSB) begin
                lsb_done_d  = 1'b1;
                lsb_rdata_d = asm_d;
              end else begin
                if_done_d = 1'b1;
                if_data_d = asm_d;
              end
            end
          end
        end
      end

      WRITE: begin
        // A byte only advances once it has actually been written (mem_wr high)
        if (mem_wr_q) begin
          if (cnt_q == len_q - 3'd1) begin
            state_d    = IDLE;
            cnt_d      = 3'd0;
            mem_wr_d   = 1'b0;
            lsb_done_d = 1'b1;
          end else begin
            cnt_d      = cnt_inc;
            mem_a_d    = mem_a_q + 32'd1;
            mem_dout_d = asm_q[7:0];
            asm_d      = asm_q >> 8;
            mem_wr_d   = !io_hold;
          end
        end else begin
          mem_wr_d = !io_hold;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = 3'd0;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      owner_q     <= OWNER_IF;
      addr_q      <= '0;
      asm_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      asm_q       <= asm_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign mem_a         = mem_a_q;
  assign mem_dout      = mem_dout_q;
  assign mem_wr        = mem_wr_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a vector table of single accesses plus
// hand-written sequences for contention, flush, IO hold, freeze and reset.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int MAXW = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        rob_clear = 1'b0;
  logic        io_full = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .rdy_in         (rdy),
    .rob_clear      (rob_clear),
    .io_buffer_full (io_full),
    .bus            (bus),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr)
  );

  always #5 clk = ~clk;

  // RAM model: read data one cycle after the address, stalled by rdy
  logic [7:0]  ram [0:262143];
  logic        poke_en = 1'b0;
  logic [17:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;

  always @(posedge clk) begin
    if (poke_en) begin
      ram[poke_addr] <= poke_data;
    end else if (rdy) begin
      mem_din <= ram[mem_a[17:0]];
      if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    end
  end

  int tests = 0;
  int fails = 0;

  logic [31:0] trace_a  [0:MAXW];
  logic        trace_wr [0:MAXW];
  logic [7:0]  trace_do [0:MAXW];

  typedef struct {
    logic        is_if;
    logic        we;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(posedge clk); #1;
    poke_en   = 1'b0;
  endtask

  task automatic issue_if(input logic [31:0] a);
    bus.if_addr = a;
    bus.if_req  = 1'b1;
  endtask

  task automatic issue_lsb(input logic we, input logic [1:0] w, input logic [31:0] a,
                           input logic [31:0] wd);
    bus.lsb_we    = we;
    bus.lsb_width = w;
    bus.lsb_addr  = a;
    bus.lsb_wdata = wd;
    bus.lsb_req   = 1'b1;
  endtask

  // Called in cycle T (just after an edge); lat is the cycle offset of done
  task automatic wait_done(input logic watch_if, output int lat, output logic [31:0] data);
    logic seen;
    lat  = -1;
    data = '0;
    seen = 1'b0;
    for (int k = 1; k <= MAXW; k++) begin
      @(posedge clk);
      @(negedge clk);
      trace_a[k]  = mem_a;
      trace_wr[k] = mem_wr;
      trace_do[k] = mem_dout;
      if (watch_if ? bus.if_done : bus.lsb_done) begin
        lat  = k;
        data = watch_if ? bus.if_data : bus.lsb_rdata;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected a done pulse", MAXW);
    end
    @(posedge clk); #1;
    if (watch_if) bus.if_req = 1'b0;
    else bus.lsb_req = 1'b0;
  endtask

  initial begin
    int          lat;
    int          nwr;
    logic [31:0] data;
    logic [7:0]  exp_b [4];

    vecs[0]  = '{1'b1, 1'b0, WIDTH_W, 32'h0000_0100, 32'h0,          32'h0000_0513, 6};
    vecs[1]  = '{1'b0, 1'b0, WIDTH_B, 32'h0000_0200, 32'h0,          32'h0000_00FF, 3};
    vecs[2]  = '{1'b0, 1'b0, WIDTH_H, 32'h0000_0300, 32'h0,          32'h0000_2211, 4};
    vecs[3]  = '{1'b0, 1'b0, WIDTH_W, 32'h0000_0300, 32'h0,          32'h4433_2211, 6};
    vecs[4]  = '{1'b0, 1'b0, WIDTH_B, 32'h0000_0303, 32'h0,          32'h0000_0044, 3};
    vecs[5]  = '{1'b0, 1'b1, WIDTH_W, 32'h0000_1000, 32'hDEAD_BEEF,  32'h0,         5};
    vecs[6]  = '{1'b0, 1'b0, WIDTH_W, 32'h0000_1000, 32'h0,          32'hDEAD_BEEF, 6};
    vecs[7]  = '{1'b0, 1'b1, WIDTH_H, 32'h0000_2000, 32'hCAFE_1234,  32'h0,         3};
    vecs[8]  = '{1'b0, 1'b0, WIDTH_H, 32'h0000_2000, 32'h0,          32'h0000_1234, 4};
    vecs[9]  = '{1'b0, 1'b1, WIDTH_B, 32'h0000_2002, 32'h1111_115A,  32'h0,         2};
    vecs[10] = '{1'b0, 1'b0, WIDTH_W, 32'h0000_2000, 32'h0,          32'h775A_1234, 6};

    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.lsb_req   = 1'b0;
    bus.lsb_we    = 1'b0;
    bus.lsb_width = WIDTH_B;
    bus.lsb_addr  = '0;
    bus.lsb_wdata = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_a",     mem_a,                  32'h0);
    check("rst_mem_wr",    {31'd0, mem_wr},        32'h0);
    check("rst_mem_dout",  {24'd0, mem_dout},      32'h0);
    check("rst_if_done",   {31'd0, bus.if_done},   32'h0);
    check("rst_lsb_done",  {31'd0, bus.lsb_done},  32'h0);
    check("rst_if_data",   bus.if_data,            32'h0);
    check("rst_lsb_rdata", bus.lsb_rdata,          32'h0);
    rst = 1'b0;

    poke(18'h00100, 8'h13);
    poke(18'h00101, 8'h05);
    poke(18'h00102, 8'h00);
    poke(18'h00103, 8'h00);
    poke(18'h00200, 8'hFF);
    poke(18'h00300, 8'h11);
    poke(18'h00301, 8'h22);
    poke(18'h00302, 8'h33);
    poke(18'h00303, 8'h44);
    poke(18'h02003, 8'h77);

    // Table-driven single accesses
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_if) issue_if(vecs[i].addr);
      else issue_lsb(vecs[i].we, vecs[i].width, vecs[i].addr, vecs[i].wdata);
      wait_done(vecs[i].is_if, lat, data);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      if (!vecs[i].we) check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      $display("[TB] vec %0d if=%0d we=%0d addr=0x%08h lat=%0d data=0x%08h",
               i, vecs[i].is_if, vecs[i].we, vecs[i].addr, lat, data);
    end

    // Fetch address trace
    issue_if(32'h100);
    wait_done(1'b1, lat, data);
    for (int k = 1; k <= 4; k++) check($sformatf("fetch_mem_a_%0d", k), trace_a[k], 32'h100 + k - 1);
    check("fetch_lat", lat, 6);
    check("fetch_data", data, 32'h0000_0513);
    $display("[TB] fetch trace addr=0x100 lat=%0d data=0x%08h", lat, data);

    // Contention: LSB wins, fetch accepted at the edge ending lsb_done
    issue_if(32'h100);
    issue_lsb(1'b0, WIDTH_B, 32'h200, 32'h0);
    wait_done(1'b0, lat, data);
    check("cont_lsb_lat", lat, 3);
    check("cont_lsb_data", data, 32'h0000_00FF);
    check("cont_fetch_start_addr", mem_a, 32'h100);
    wait_done(1'b1, lat, data);
    check("cont_fetch_lat", lat, 5);
    check("cont_fetch_data", data, 32'h0000_0513);
    $display("[TB] contention lsb then fetch, fetch lat=%0d data=0x%08h", lat, data);

    // Store word byte trace
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    issue_lsb(1'b1, WIDTH_W, 32'h1010, 32'hDEAD_BEEF);
    wait_done(1'b0, lat, data);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("store_wr_%0d", k),   {31'd0, trace_wr[k]}, 32'h1);
      check($sformatf("store_a_%0d", k),    trace_a[k], 32'h1010 + k - 1);
      check($sformatf("store_dout_%0d", k), {24'd0, trace_do[k]}, {24'd0, exp_b[k-1]});
    end
    check("store_lat", lat, 5);
    check("store_wr_after", {31'd0, trace_wr[5]}, 32'h0);
    $display("[TB] store word addr=0x1010 lat=%0d", lat);

    // Flush during fetch: aborted, new fetch accepted at T+3
    issue_if(32'h100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rob_clear = 1'b1;
    @(posedge clk); #1;
    rob_clear = 1'b0;
    bus.if_addr = 32'h300;
    wait_done(1'b1, lat, data);
    check("flush_refetch_addr", trace_a[1], 32'h300);
    check("flush_lat", lat, 6);
    check("flush_data", data, 32'h4433_2211);
    $display("[TB] flush then refetch addr=0x300 lat=%0d data=0x%08h", lat, data);

    // IO hold: buffer full for cycles T..T+2
    io_full = 1'b1;
    issue_lsb(1'b1, WIDTH_B, 32'h0003_0000, 32'h0000_00A5);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 io_full = 1'b0;
      end
    join_none
    wait_done(1'b0, lat, data);
    nwr = 0;
    for (int k = 1; k <= MAXW; k++) if (k <= lat && trace_wr[k]) nwr++;
    check("io_lat", lat, 5);
    check("io_write_count", nwr, 1);
    check("io_wr_hold", {31'd0, trace_wr[3]}, 32'h0);
    check("io_wr_cycle", {31'd0, trace_wr[4]}, 32'h1);
    check("io_dout", {24'd0, trace_do[4]}, 32'h0000_00A5);
    check("io_ram", {24'd0, ram[18'h30000]}, 32'h0000_00A5);
    $display("[TB] io store addr=0x30000 lat=%0d writes=%0d", lat, nwr);

    // Freeze: rdy low for 5 cycles mid-fetch
    issue_if(32'h300);
    fork
      begin
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1 rdy = 1'b1;
      end
    join_none
    wait_done(1'b1, lat, data);
    check("freeze_a_hold", trace_a[6], 32'h301);
    check("freeze_a_resume", trace_a[8], 32'h302);
    check("freeze_lat", lat, 11);
    check("freeze_data", data, 32'h4433_2211);
    $display("[TB] freeze fetch addr=0x300 lat=%0d data=0x%08h", lat, data);

    // Reset in the middle of a store
    issue_lsb(1'b1, WIDTH_W, 32'h1100, 32'hA1B2_C3D4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_mem_wr",    {31'd0, mem_wr},       32'h0);
    check("mrst_mem_a",     mem_a,                 32'h0);
    check("mrst_mem_dout",  {24'd0, mem_dout},     32'h0);
    check("mrst_lsb_done",  {31'd0, bus.lsb_done}, 32'h0);
    check("mrst_if_done",   {31'd0, bus.if_done},  32'h0);
    check("mrst_if_data",   bus.if_data,           32'h0);
    check("mrst_lsb_rdata", bus.lsb_rdata,         32'h0);
    rst = 1'b0;
    bus.lsb_req = 1'b0;
    $display("[TB] reset during store addr=0x1100");

    // Controller usable again after reset
    @(posedge clk); #1;
    issue_if(32'h100);
    wait_done(1'b1, lat, data);
    check("post_rst_lat", lat, 6);
    check("post_rst_data", data, 32'h0000_0513);
    $display("[TB] post-reset fetch lat=%0d data=0x%08h", lat, data);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
